bist_ctrl_s820: RTL

Built-in self-test controller for the s820 benchmark core. It drives the core's 18 primary inputs with an 18-bit LFSR pattern stream for a programmable number of cycles. It compacts the core's 19 primary outputs into a 19-bit MISR signature and compares that signature against a golden value. It sits between the chip-level test port and the core, and owns the core's reset during a test run.

---
 rtl/bist_ctrl_s820.sv | 87 ++++++++
 1 files changed

// File: rtl/bist_ctrl_s820.sv
// BIST controller for the s820 core: LFSR pattern source, MISR response compactor,
// programmable run length and golden-signature compare.
module bist_ctrl_s820 #(
    parameter int unsigned NPAT = 256,
    parameter logic [17:0] SEED = 18'h00001
) (
    input  logic        blif_clk_net,
    input  logic        blif_reset_net,
    input  logic        start,
    input  logic [18:0] golden_sig,
    input  logic [18:0] po_in,
    output logic [17:0] pi_out,
    output logic        dut_rst,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [18:0] sig_out
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // An all-zero LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [17:0] SEED_EFF = (SEED == 18'h00000) ? 18'h00001 : SEED;
    localparam logic [15:0] LAST     = 16'(NPAT - 1);

    logic [2:0]  state;
    logic        init_second;
    logic [15:0] cnt;
    logic [17:0] lfsr;
    logic [18:0] misr;
    logic        pass_q;
    logic        misr_fb;

    assign misr_fb = misr[18] ^ misr[5] ^ misr[1] ^ misr[0];

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            state       <= S_IDLE;
            init_second <= 1'b0;
            cnt         <= '0;
            lfsr        <= SEED_EFF;
            misr        <= '0;
            pass_q      <= 1'b0;
        end else begin
            // Marks the second INIT cycle; cleared everywhere else.
            init_second <= (state == S_INIT) && !init_second;
            case (state)
                S_IDLE: begin
                    if (start) state <= S_INIT;
                end
                S_INIT: begin
                    lfsr   <= SEED_EFF;
                    misr   <= '0;
                    cnt    <= '0;
                    pass_q <= 1'b0;
                    if (init_second) state <= S_RUN;
                end
                S_RUN: begin
                    lfsr <= {lfsr[16:0], lfsr[17] ^ lfsr[10]};
                    misr <= {misr[17:0], misr_fb} ^ po_in;
                    cnt  <= cnt + 16'd1;
                    if (cnt == LAST) state <= S_CMP;
                end
                S_CMP: begin
                    pass_q <= (misr == golden_sig);
                    state  <= S_DONE;
                end
                S_DONE: begin
                    if (start) state <= S_INIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state == S_INIT) || (state == S_RUN) || (state == S_CMP);
    assign done    = (state == S_DONE);
    assign dut_rst = (state == S_INIT);
    assign pi_out  = (state == S_RUN) ? lfsr : '0;
    assign pass    = pass_q;
    assign sig_out = misr;

endmodule
